// File: rtl/regfile_host_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_host_arbiter
//
// Shares the register block between the CPU pipeline (core) and a host
// debug/test port. The core normally owns the register block ports. The
// register block outputs simply follow the core requests. A pending host
// request is served in a single-cycle GRANT slot in either of two cases:
//   - the core leaves the ports idle, or
//   - the host has been denied STARVE_LIMIT consecutive cycles.
// During a GRANT slot the core is stalled. An ACK cycle follows the GRANT
// slot and pulses host_ack.
//
// Parameters:
//   STARVE_LIMIT  denied cycles tolerated before a host slot is forced
//                 (1 .. 2^CNT_W-1)
//   CNT_W         width of the starvation counter
//   GCNT_W        width of the host grant counter (wraps)
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   core_*              pipeline read/write requests (decode/writeback)
//   core_stall          core must hold its request this cycle
//   host_req/we/addr/wdata   host request (req/ack handshake)
//   host_ack            one-cycle completion pulse
//   host_rdata          result of the most recent host read
//   rf_*                register block enables/addresses/write data
//   rf_rs_data          register block rs read data (updates on negedge)
//   host_grant_count    number of host slots granted
// -----------------------------------------------------------------------------
module regfile_host_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4,
    parameter int GCNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_rs_re,
    input  logic              core_rt_re,
    input  logic              core_rd_we,
    input  logic [4:0]        core_rs_addr,
    input  logic [4:0]        core_rt_addr,
    input  logic [4:0]        core_rd_addr,
    input  logic [31:0]       core_rd_data,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [4:0]        host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_ack,
    output logic [31:0]       host_rdata,
    output logic              rf_rs_re,
    output logic              rf_rt_re,
    output logic              rf_rd_we,
    output logic [4:0]        rf_rs_addr,
    output logic [4:0]        rf_rt_addr,
    output logic [4:0]        rf_rd_addr,
    output logic [31:0]       rf_rd_data,
    input  logic [31:0]       rf_rs_data,
    output logic [GCNT_W-1:0] host_grant_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  STARVE_LIM_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_ONE_C    = CNT_W'(1);
    localparam logic [GCNT_W-1:0] GCNT_ONE_C   = GCNT_W'(1);

    state_t             state_r;
    logic [CNT_W-1:0]   starve_cnt_r;
    logic               lat_we_r;
    logic [4:0]         lat_addr_r;
    logic [31:0]        lat_wdata_r;
    logic               core_stall_r;
    logic               host_ack_r;
    logic [31:0]        host_rdata_r;
    logic [GCNT_W-1:0]  grant_cnt_r;

    logic               core_active_s;
    logic               starve_hit_s;
    logic               take_host_s;

    // Decide whether a pending host request wins the ports at the next edge.
    always_comb begin
        core_active_s = core_rs_re | core_rt_re | core_rd_we;
        starve_hit_s  = (starve_cnt_r == STARVE_LIM_C);
        take_host_s   = host_req & (~core_active_s | starve_hit_s);
    end

    // Arbitration FSM: slot sequencing, host field latch, counters, flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= '0;
            lat_we_r     <= 1'b0;
            lat_addr_r   <= 5'd0;
            lat_wdata_r  <= 32'd0;
            core_stall_r <= 1'b0;
            host_ack_r   <= 1'b0;
            host_rdata_r <= 32'd0;
            grant_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    host_ack_r <= 1'b0;
                    if (take_host_s) begin
                        state_r      <= ST_GRANT;
                        lat_we_r     <= host_we;
                        lat_addr_r   <= host_addr;
                        lat_wdata_r  <= host_wdata;
                        grant_cnt_r  <= grant_cnt_r + GCNT_ONE_C;
                        starve_cnt_r <= '0;
                        core_stall_r <= 1'b1;
                    end else if (host_req) begin
                        // Denied because the core is busy; count toward the
                        // forced slot (saturates at the limit, where the
                        // next request is taken anyway).
                        state_r      <= ST_IDLE;
                        core_stall_r <= 1'b0;
                        if (starve_cnt_r < STARVE_LIM_C) begin
                            starve_cnt_r <= starve_cnt_r + CNT_ONE_C;
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else begin
                        state_r      <= ST_IDLE;
                        core_stall_r <= 1'b0;
                        starve_cnt_r <= '0;
                    end
                end
                ST_GRANT: begin
                    // The rs read issued during GRANT is visible on
                    // rf_rs_data by this edge (register block updates on
                    // the falling edge).
                    state_r      <= ST_ACK;
                    core_stall_r <= 1'b0;
                    host_ack_r   <= 1'b1;
                    if (!lat_we_r) begin
                        host_rdata_r <= rf_rs_data;
                    end else begin
                        host_rdata_r <= host_rdata_r;
                    end
                end
                ST_ACK: begin
                    // host_req is deliberately ignored here; a request
                    // still held is re-evaluated as new in IDLE.
                    state_r      <= ST_IDLE;
                    core_stall_r <= 1'b0;
                    host_ack_r   <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    core_stall_r <= 1'b0;
                    host_ack_r   <= 1'b0;
                    starve_cnt_r <= '0;
                end
            endcase
        end
    end

    // Register block port mux: latched host access in GRANT, core otherwise.
    always_comb begin
        rf_rs_re   = core_rs_re;
        rf_rt_re   = core_rt_re;
        rf_rd_we   = core_rd_we;
        rf_rs_addr = core_rs_addr;
        rf_rt_addr = core_rt_addr;
        rf_rd_addr = core_rd_addr;
        rf_rd_data = core_rd_data;
        if (state_r == ST_GRANT) begin
            rf_rs_re   = ~lat_we_r;
            rf_rt_re   = 1'b0;
            rf_rd_we   = lat_we_r;
            rf_rs_addr = lat_addr_r;
            rf_rt_addr = 5'd0;
            rf_rd_addr = lat_addr_r;
            rf_rd_data = lat_wdata_r;
        end else begin
            rf_rs_re   = core_rs_re;
            rf_rt_re   = core_rt_re;
            rf_rd_we   = core_rd_we;
        end
    end

    // Registered status outputs.
    always_comb begin
        core_stall       = core_stall_r;
        host_ack         = host_ack_r;
        host_rdata       = host_rdata_r;
        host_grant_count = grant_cnt_r;
    end

endmodule

// File: doc/regfile_host_arbiter.md
Name: regfile_host_arbiter

Overview:
Shares the single register block between the CPU pipeline (core) and a host debug/test port. The host uses a req/ack handshake to read or write any register, e.g. to preload r2/r3 or poll r4/r5/r6. The core has priority over the host. A bounded-starvation counter forces a one-cycle host slot, stalling the core, when the core keeps the ports busy. The block sits between the pipeline's decode/writeback signals and the register block's ports.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a pending host request may be denied before a slot is forced; legal range 1..2^CNT_W-1
CNT_W, 4, width of the starvation counter
GCNT_W, 16, width of the host grant counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
core_rs_re  in  1  core rs read enable
core_rt_re  in  1  core rt read enable
core_rd_we  in  1  core write enable
core_rs_addr  in  5  core rs address
core_rt_addr  in  5  core rt address
core_rd_addr  in  5  core write address
core_rd_data  in  32  core write data
core_stall  out  1  core must hold its request this cycle
host_req  in  1  host request
host_we  in  1  1=write, 0=read
host_addr  in  5  host register address
host_wdata  in  32  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  32  last host read result
rf_rs_re, rf_rt_re, rf_rd_we  out  1 each  register block enables
rf_rs_addr, rf_rt_addr, rf_rd_addr  out  5 each  register block addresses
rf_rd_data  out  32  register block write data
rf_rs_data  in  32  register block rs output (updates on negedge)
host_grant_count  out  GCNT_W  number of host slots granted, wraps at 2^GCNT_W

Behaviour:
- State machine:
  - IDLE: rf_* outputs are a combinational pass-through of core_*. core_stall=0. host_ack=0.
  - GRANT (exactly 1 cycle): rf_* outputs are driven from the latched host request. core_stall=1.
  - ACK (exactly 1 cycle): rf_* is core pass-through. host_ack=1.
- core_active = core_rs_re | core_rt_re | core_rd_we.
- IDLE -> GRANT at a posedge when host_req=1 and either core_active=0 or starve_cnt==STARVE_LIMIT.
  - On this edge, latch host_we, host_addr and host_wdata.
  - Increment host_grant_count.
  - Clear starve_cnt.
- In IDLE with host_req=1, core_active=1 and starve_cnt<STARVE_LIMIT: starve_cnt increments.
- In IDLE with host_req=0: starve_cnt clears.
- GRANT, host read: rf_rs_re=1, rf_rs_addr=latched addr, rf_rt_re=0, rf_rd_we=0. At the posedge ending GRANT, host_rdata <= rf_rs_data.
- GRANT, host write: rf_rd_we=1, rf_rd_addr/rf_rd_data = latched addr/data, both read enables 0. host_rdata is unchanged.
- GRANT -> ACK unconditionally. ACK -> IDLE unconditionally.
- host_req is not sampled in GRANT or ACK. A request still held in IDLE after ACK is treated as a new request.
- Latency with the core idle: req seen at edge N → GRANT in cycle N, ACK in cycle N+1. Minimum spacing between two acks is 3 cycles.
- A host write to r0 completes with a normal ack. The register block discards the write, so a subsequent read of r0 returns 0.
- The core must hold all core_* inputs stable while core_stall=1. Core requests made in a GRANT cycle are not forwarded.
- Reset (async, any state) clears:
  - state to IDLE;
  - host_ack, host_rdata, starve_cnt, host_grant_count and the latched host fields to 0;
  - core_stall to 0.
  - An in-flight host request is dropped with no ack; the host must re-request.
- host_grant_count wraps from 2^GCNT_W-1 to 0.

Test Plan:
1. Register block reset with initial_floors=100; core idle; host read addr 2 → GRANT next cycle, host_ack one cycle later with host_rdata=100; core_stall high exactly 1 cycle.
2. Host write addr 4 = 7, then host read addr 4 → second ack returns host_rdata=7; acks spaced ≥3 cycles; host_grant_count=2.
3. core_rs_re held high continuously; host read addr 3 (initial_resistance=0x55) with STARVE_LIMIT=4 → GRANT after exactly 4 denied cycles; core_stall 1 cycle; host_rdata=0x55; starve_cnt=0 afterwards.
4. Host write r0=0xDEADBEEF, then read r0 → host_rdata=0.
5. Reset asserted during GRANT of a host write → no ack; state IDLE; core_stall=0; host_rdata=0; host_grant_count=0; the target register keeps its reset value.
6. host_req held high with the core idle → acks at cycles 2, 5, 8, …; no rf_rd_we/rf_rs_re from the host outside GRANT cycles.
